// File: rtl/systolic_controller.sv
// Instruction sequencer for the systolic array: assembles buffer write payloads and
// sequences weight loading, matrix-multiply streaming with drain, and result write-back.
module systolic_controller #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int ROWS   = 16,
    parameter int DRAIN  = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              write_data,
    output logic              write_weight,
    output logic              read_en,
    output logic              load_weight,
    output logic              mat_mul,
    output logic              write_result,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              illegal
);
    localparam int CNT_W = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_WRITE, S_LOADW, S_MM_RD, S_MM_DRAIN, S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [1:0]         word_idx_q, word_idx_d;
    logic               is_weight_q, is_weight_d;
    logic [ADDR_W-1:0]  addra_q, addra_d, addrb_q, addrb_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               write_data_q, write_data_d, write_weight_q, write_weight_d;
    logic               read_en_q, read_en_d, load_weight_q, load_weight_d;
    logic               mat_mul_q, mat_mul_d, write_result_q, write_result_d;
    logic               illegal_q, illegal_d, ready_q, ready_d, busy_q, busy_d;

    logic [3:0]         op;
    logic [7:0]         cnt;
    logic [ADDR_W-1:0]  addr_f;
    logic               accept;

    assign op     = instruction[31:28];
    assign cnt    = instruction[15:8];
    assign addr_f = instruction[ADDR_W-1:0];
    assign accept = instr_valid && ready_q;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        word_idx_d     = word_idx_q;
        is_weight_d    = is_weight_q;
        addra_d        = addra_q;
        addrb_d        = addrb_q;
        dout_d         = dout_q;
        write_data_d   = 1'b0;
        write_weight_d = 1'b0;
        read_en_d      = 1'b0;
        load_weight_d  = 1'b0;
        mat_mul_d      = 1'b0;
        write_result_d = 1'b0;
        illegal_d      = 1'b0;

        // rem_q counts the cycles left in the current state, including this one.
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        4'd0: ;
                        4'd1, 4'd2: begin
                            state_d     = S_PAYLOAD;
                            addra_d     = addr_f;
                            word_idx_d  = 2'd0;
                            is_weight_d = (op == 4'd2);
                        end
                        4'd3: begin
                            state_d   = S_LOADW;
                            rem_d     = CNT_W'(ROWS + 1);
                            read_en_d = 1'b1;
                            addrb_d   = addr_f;
                        end
                        4'd4: begin
                            if (cnt != 8'd0) begin
                                state_d   = S_MM_RD;
                                rem_d     = CNT_W'(cnt);
                                read_en_d = 1'b1;
                                mat_mul_d = 1'b1;
                                addrb_d   = addr_f;
                            end
                        end
                        4'd5: begin
                            state_d        = S_RESULT;
                            rem_d          = CNT_W'(ROWS);
                            write_result_d = 1'b1;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    for (int k = 0; k < 4; k++) begin
                        if (word_idx_q == 2'(k)) begin
                            dout_d[DATA_W-1-32*k -: 32] = instruction;
                        end
                    end
                    word_idx_d = word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) begin
                        state_d        = S_WRITE;
                        write_weight_d = is_weight_q;
                        write_data_d   = !is_weight_q;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_LOADW: begin
                // load_weight trails read_en by one cycle to cover BRAM read latency.
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d         = rem_q - CNT_W'(1);
                    load_weight_d = 1'b1;
                    if (rem_q > CNT_W'(2)) begin
                        read_en_d = 1'b1;
                        addrb_d   = addrb_q + ADDR_W'(1);
                    end
                end
            end
            S_MM_RD: begin
                mat_mul_d = 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_MM_DRAIN;
                    rem_d   = CNT_W'(DRAIN);
                end else begin
                    rem_d     = rem_q - CNT_W'(1);
                    read_en_d = 1'b1;
                    addrb_d   = addrb_q + ADDR_W'(1);
                end
            end
            S_MM_DRAIN: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d     = rem_q - CNT_W'(1);
                    mat_mul_d = 1'b1;
                end
            end
            S_RESULT: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d          = rem_q - CNT_W'(1);
                    write_result_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rem_q          <= '0;
            word_idx_q     <= '0;
            is_weight_q    <= 1'b0;
            addra_q        <= '0;
            addrb_q        <= '0;
            dout_q         <= '0;
            write_data_q   <= 1'b0;
            write_weight_q <= 1'b0;
            read_en_q      <= 1'b0;
            load_weight_q  <= 1'b0;
            mat_mul_q      <= 1'b0;
            write_result_q <= 1'b0;
            illegal_q      <= 1'b0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            word_idx_q     <= word_idx_d;
            is_weight_q    <= is_weight_d;
            addra_q        <= addra_d;
            addrb_q        <= addrb_d;
            dout_q         <= dout_d;
            write_data_q   <= write_data_d;
            write_weight_q <= write_weight_d;
            read_en_q      <= read_en_d;
            load_weight_q  <= load_weight_d;
            mat_mul_q      <= mat_mul_d;
            write_result_q <= write_result_d;
            illegal_q      <= illegal_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
        end
    end

    assign instr_ready  = ready_q;
    assign write_data   = write_data_q;
    assign write_weight = write_weight_q;
    assign read_en      = read_en_q;
    assign load_weight  = load_weight_q;
    assign mat_mul      = mat_mul_q;
    assign write_result = write_result_q;
    assign addra        = addra_q;
    assign addrb        = addrb_q;
    assign dout         = dout_q;
    assign busy         = busy_q;
    assign illegal      = illegal_q;
endmodule

// File: tb/tb_systolic_controller.sv
// Directed self-checking bench for systolic_controller: payload assembly, weight load
// with address wrap, mat-mul drain timing, illegal opcodes and mid-operation reset.
module tb_systolic_controller;
    logic         clk;
    logic         reset_n;
    logic [31:0]  instruction;
    logic         instr_valid;
    logic         instr_ready;
    logic         write_data, write_weight, read_en, load_weight, mat_mul, write_result;
    logic [7:0]   addra, addrb;
    logic [127:0] dout;
    logic         busy, illegal;

    int n_checks = 0;
    int n_errors = 0;
    int n_wd = 0, n_ww = 0, n_re = 0, n_lw = 0, n_mm = 0, n_wr = 0, n_ill = 0;

    systolic_controller dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .write_data(write_data), .write_weight(write_weight),
        .read_en(read_en), .load_weight(load_weight), .mat_mul(mat_mul),
        .write_result(write_result), .addra(addra), .addrb(addrb), .dout(dout),
        .busy(busy), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        n_wd  <= n_wd  + int'(write_data);
        n_ww  <= n_ww  + int'(write_weight);
        n_re  <= n_re  + int'(read_en);
        n_lw  <= n_lw  + int'(load_weight);
        n_mm  <= n_mm  + int'(mat_mul);
        n_wr  <= n_wr  + int'(write_result);
        n_ill <= n_ill + int'(illegal);
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int waits;
        waits = 0;
        instruction = w;
        instr_valid = 1'b1;
        while (!instr_ready && waits < 200) begin
            tick();
            waits++;
        end
        if (!instr_ready) check_eq("send_timeout", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, instr_ready, 1'b1);
        check_eq({tag, "_strobes"}, {write_data, write_weight, read_en, load_weight,
                                     mat_mul, write_result, illegal}, 7'b0);
        check_eq({tag, "_addra"}, addra, 8'h00);
        check_eq({tag, "_addrb"}, addrb, 8'h00);
        check_eq({tag, "_dout"}, dout, 128'h0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wd, s_ww, s_re, s_lw, s_mm, s_wr, s_ill;
        reset_n = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'h0;
        tick();
        tick();
        check_reset_state("reset");
        reset_n = 1'b1;
        tick();

        // WRITE_DATA addr 0x10, back-to-back payload
        s_wd = n_wd;
        send(32'h1000_0010);
        check_eq("wd_busy", busy, 1'b1);
        check_eq("wd_ready_payload", instr_ready, 1'b1);
        send(32'h1111_1111);
        send(32'h2222_2222);
        send(32'h3333_3333);
        send(32'h4444_4444);
        check_eq("wd_strobe", write_data, 1'b1);
        check_eq("wd_ready_low", instr_ready, 1'b0);
        check_eq("wd_addra", addra, 8'h10);
        check_eq("wd_dout", dout, 128'h11111111_22222222_33333333_44444444);
        tick();
        check_eq("wd_idle_busy", busy, 1'b0);
        check_eq("wd_idle_ready", instr_ready, 1'b1);
        check_eq("wd_pulses", n_wd - s_wd, 1);

        // LOAD_WEIGHT addr 0xF8 with wrap
        s_re = n_re; s_lw = n_lw;
        send(32'h3000_00F8);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] exp_a;
            exp_a = 8'hF8 + 8'(i);
            check_eq($sformatf("lw_re_%0d", i), read_en, (i < 16));
            check_eq($sformatf("lw_lw_%0d", i), load_weight, (i >= 1));
            check_eq($sformatf("lw_busy_%0d", i), busy, 1'b1);
            if (i < 16) check_eq($sformatf("lw_addrb_%0d", i), addrb, exp_a);
            tick();
        end
        check_eq("lw_end_busy", busy, 1'b0);
        check_eq("lw_re_total", n_re - s_re, 16);
        check_eq("lw_lw_total", n_lw - s_lw, 16);

        // MAT_MUL cnt 4 addr 0x20
        s_mm = n_mm;
        send(32'h4000_0420);
        for (int i = 0; i < 35; i++) begin
            logic [7:0] exp_a;
            exp_a = 8'h20 + 8'(i);
            check_eq($sformatf("mm_re_%0d", i), read_en, (i < 4));
            check_eq($sformatf("mm_mm_%0d", i), mat_mul, 1'b1);
            check_eq($sformatf("mm_ready_%0d", i), instr_ready, 1'b0);
            if (i < 4) check_eq($sformatf("mm_addrb_%0d", i), addrb, exp_a);
            tick();
        end
        check_eq("mm_end_mm", mat_mul, 1'b0);
        check_eq("mm_end_busy", busy, 1'b0);
        check_eq("mm_total", n_mm - s_mm, 35);

        // MAT_MUL cnt 0 acts as NOP
        s_re = n_re; s_mm = n_mm;
        send(32'h4000_0020);
        check_eq("mm0_busy", busy, 1'b0);
        tick(); tick();
        check_eq("mm0_strobes", (n_re - s_re) + (n_mm - s_mm), 0);

        // WRITE_WEIGHT addr 0x33 with a 3-cycle valid gap between words 2 and 3
        s_ww = n_ww; s_wd = n_wd;
        send(32'h2000_0033);
        send(32'hA5A5_0001);
        send(32'hB6B6_0002);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ww_gap_ready_%0d", i), instr_ready, 1'b1);
            check_eq($sformatf("ww_gap_strobe_%0d", i), write_weight, 1'b0);
            check_eq($sformatf("ww_gap_dout_%0d", i), dout[127:64], 64'hA5A50001_B6B60002);
            tick();
        end
        send(32'hC7C7_0003);
        send(32'hD8D8_0004);
        check_eq("ww_strobe", write_weight, 1'b1);
        check_eq("ww_addra", addra, 8'h33);
        check_eq("ww_dout", dout, 128'hA5A50001_B6B60002_C7C70003_D8D80004);
        tick();
        check_eq("ww_pulses", n_ww - s_ww, 1);
        check_eq("ww_no_wd", n_wd - s_wd, 0);

        // WRITE_RESULT
        s_wr = n_wr;
        send(32'h5000_0000);
        for (int i = 0; i < 16; i++) tick();
        check_eq("wr_end_busy", busy, 1'b0);
        check_eq("wr_total", n_wr - s_wr, 16);

        // Illegal opcode, then immediate NOP
        s_ill = n_ill;
        send(32'hF000_0000);
        check_eq("ill_pulse", illegal, 1'b1);
        check_eq("ill_busy", busy, 1'b0);
        check_eq("ill_ready", instr_ready, 1'b1);
        send(32'h0000_0000);
        check_eq("nop_illegal", illegal, 1'b0);
        check_eq("nop_busy", busy, 1'b0);
        check_eq("ill_count", n_ill - s_ill, 1);

        // Reset during MM_DRAIN
        send(32'h4000_0240);
        for (int i = 0; i < 10; i++) tick();
        check_eq("drain_mm", mat_mul, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset_state("rst_drain");

        // Reset while word 2 of a payload is presented
        send(32'h1000_0050);
        send(32'hDEAD_BEEF);
        instruction = 32'hFEED_F00D;
        instr_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        instr_valid = 1'b0;
        reset_n = 1'b1;
        check_reset_state("rst_payload");

        s_wd = n_wd;
        send(32'h1000_0060);
        send(32'h0102_0304);
        send(32'h0506_0708);
        send(32'h090A_0B0C);
        send(32'h0D0E_0F10);
        check_eq("fresh_strobe", write_data, 1'b1);
        check_eq("fresh_addra", addra, 8'h60);
        check_eq("fresh_dout", dout, 128'h01020304_05060708_090A0B0C_0D0E0F10);
        tick();
        check_eq("fresh_pulses", n_wd - s_wd, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
